// File: rtl/unpack_arb.sv
// unpack_arb: packet-atomic arbiter that lets two packet sources share one unpacker.
// Define UNPACK_ARB_FIXED_PRIO_EN to make IDLE ties always favour port 0 instead of round-robin.
module unpack_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [31:0] s0_data,
    input  logic        s0_sop,
    input  logic        s0_eop,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [31:0] s1_data,
    input  logic        s1_sop,
    input  logic        s1_eop,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_sop,
    output logic        m_eop,
    output logic        grant_id,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_served;
    logic        last_served_next;
    logic [7:0]  drop_next;

    logic        elig0;
    logic        elig1;
    logic        tie_pick;
    logic        has_owner;
    logic        owner;
    logic        sel_valid;
    logic        sel_sop;
    logic        sel_eop;
    logic [31:0] sel_data;
    logic        handshake;
    logic        orphan0;
    logic        orphan1;
    logic [8:0]  drop_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            drop_cnt    <= 8'd0;
        end else begin
            state       <= state_next;
            last_served <= last_served_next;
            drop_cnt    <= drop_next;
        end
    end

    // The owner is either the packet holder or, in IDLE, the port granted this very cycle.
    always_comb begin
        elig0 = s0_valid & s0_sop;
        elig1 = s1_valid & s1_sop;
`ifdef UNPACK_ARB_FIXED_PRIO_EN
        tie_pick = 1'b0;
`else
        tie_pick = ~last_served;
`endif
        has_owner = 1'b0;
        owner     = last_served;
        case (state)
            OWN0: begin
                has_owner = 1'b1;
                owner     = 1'b0;
            end
            OWN1: begin
                has_owner = 1'b1;
                owner     = 1'b1;
            end
            default: begin
                if (elig0 && elig1) begin
                    has_owner = 1'b1;
                    owner     = tie_pick;
                end else if (elig0) begin
                    has_owner = 1'b1;
                    owner     = 1'b0;
                end else if (elig1) begin
                    has_owner = 1'b1;
                    owner     = 1'b1;
                end
            end
        endcase
        if (rst) begin
            has_owner = 1'b0;
            owner     = 1'b1;
        end

        sel_valid = owner ? s1_valid : s0_valid;
        sel_data  = owner ? s1_data  : s0_data;
        sel_sop   = owner ? s1_sop   : s0_sop;
        sel_eop   = owner ? s1_eop   : s0_eop;

        m_valid   = has_owner & sel_valid;
        m_data    = m_valid ? sel_data : 32'd0;
        m_sop     = m_valid & sel_sop;
        m_eop     = m_valid & sel_eop;
        handshake = m_valid & m_ready;

        // Continuation words from a port that does not own the output are swallowed.
        orphan0 = ~rst & s0_valid & ~s0_sop & ~(has_owner & ~owner);
        orphan1 = ~rst & s1_valid & ~s1_sop & ~(has_owner & owner);

        s0_ready = (has_owner & ~owner) ? m_ready : orphan0;
        s1_ready = (has_owner &  owner) ? m_ready : orphan1;

        busy     = ~rst & ((state != IDLE) | handshake);
        grant_id = has_owner ? owner : last_served;

        state_next       = state;
        last_served_next = last_served;
        if (handshake && sel_eop) begin
            state_next       = IDLE;
            last_served_next = owner;
        end else if (handshake && (state == IDLE)) begin
            state_next = owner ? OWN1 : OWN0;
        end

        drop_sum  = {1'b0, drop_cnt} + 9'(orphan0) + 9'(orphan1);
        drop_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

endmodule

// File: tb/tb_unpack_arb.sv
// tb_unpack_arb: vector table, directed corner sequences and a randomized run against a packet-level model.
module tb_unpack_arb;

`ifdef UNPACK_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s0_ready, s0_sop, s0_eop;
    logic [31:0] s0_data;
    logic        s1_valid, s1_ready, s1_sop, s1_eop;
    logic [31:0] s1_data;
    logic        m_valid, m_ready, m_sop, m_eop;
    logic [31:0] m_data;
    logic        grant_id, busy;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        v0, sop0, eop0;
        logic [31:0] d0;
        logic        v1, sop1, eop1;
        logic [31:0] d1;
        logic        mr;
    } stim_t;

    typedef struct {
        logic        mv;
        logic [31:0] md;
        logic        msop, meop, r0, r1, gid, busy;
        logic [7:0]  drop;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: owner -1 means no packet in flight.
    int mOwner;
    bit mLast;
    int mDrops;

    unpack_arb dut (
        .clk      (clk),
        .rst      (rst),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_data  (s0_data),
        .s0_sop   (s0_sop),
        .s0_eop   (s0_eop),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_data  (s1_data),
        .s1_sop   (s1_sop),
        .s1_eop   (s1_eop),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_sop    (m_sop),
        .m_eop    (m_eop),
        .grant_id (grant_id),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic stim_t st(logic v0, logic sop0, logic eop0, logic [31:0] d0,
                                 logic v1, logic sop1, logic eop1, logic [31:0] d1, logic mr);
        stim_t s;
        s.v0 = v0; s.sop0 = sop0; s.eop0 = eop0; s.d0 = d0;
        s.v1 = v1; s.sop1 = sop1; s.eop1 = eop1; s.d1 = d1;
        s.mr = mr;
        return s;
    endfunction

    function automatic exp_t ex(logic mv, logic [31:0] md, logic msop, logic meop,
                                logic r0, logic r1, logic gid, logic bsy, logic [7:0] drop);
        exp_t e;
        e.mv = mv; e.md = md; e.msop = msop; e.meop = meop;
        e.r0 = r0; e.r1 = r1; e.gid = gid; e.busy = bsy; e.drop = drop;
        return e;
    endfunction

    task automatic addVec(input stim_t s, input exp_t e);
        vec_t v;
        v.s = s;
        v.e = e;
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input stim_t s);
        s0_valid = s.v0; s0_sop = s.sop0; s0_eop = s.eop0; s0_data = s.d0;
        s1_valid = s.v1; s1_sop = s.sop1; s1_eop = s.eop1; s1_data = s.d1;
        m_ready  = s.mr;
    endtask

    task automatic checkField(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input exp_t e);
        checkField(name, "m_valid",  32'(m_valid),  32'(e.mv));
        checkField(name, "m_data",   m_data,        e.md);
        checkField(name, "m_sop",    32'(m_sop),    32'(e.msop));
        checkField(name, "m_eop",    32'(m_eop),    32'(e.meop));
        checkField(name, "s0_ready", 32'(s0_ready), 32'(e.r0));
        checkField(name, "s1_ready", 32'(s1_ready), 32'(e.r1));
        checkField(name, "grant_id", 32'(grant_id), 32'(e.gid));
        checkField(name, "busy",     32'(busy),     32'(e.busy));
        checkField(name, "drop_cnt", 32'(drop_cnt), 32'(e.drop));
    endtask

    // One clock cycle: drive after the rising edge, compare on the falling edge.
    task automatic cycle(input string name, input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        applyStimulus(s);
        @(negedge clk);
        checkOutput(name, e);
    endtask

    // Expected behaviour derived from the arbitration rules, one cycle at a time.
    task automatic modelStep(input stim_t s, output exp_t e);
        bit          v[2], sop[2], eop[2];
        logic [31:0] d[2];
        bit          rdy[2];
        int          g;
        int          orphans;
        bit          fwd;
        v[0] = s.v0;   v[1] = s.v1;
        sop[0] = s.sop0; sop[1] = s.sop1;
        eop[0] = s.eop0; eop[1] = s.eop1;
        d[0] = s.d0;   d[1] = s.d1;

        if (mOwner >= 0) begin
            g = mOwner;
        end else begin
            bit e0, e1;
            e0 = v[0] && sop[0];
            e1 = v[1] && sop[1];
            if (e0 && e1)  g = FIXED ? 0 : 1 - int'(mLast);
            else if (e0)   g = 0;
            else if (e1)   g = 1;
            else           g = -1;
        end

        fwd = (g >= 0) && v[g];
        orphans = 0;
        for (int k = 0; k < 2; k++) begin
            if (k == g) begin
                rdy[k] = s.mr;
            end else begin
                rdy[k] = v[k] && !sop[k];
                if (rdy[k]) orphans++;
            end
        end

        e.mv   = fwd;
        e.md   = fwd ? d[g] : 32'd0;
        e.msop = fwd && sop[g];
        e.meop = fwd && eop[g];
        e.r0   = rdy[0];
        e.r1   = rdy[1];
        e.gid  = (g >= 0) ? (g == 1) : mLast;
        e.busy = (mOwner >= 0) || (fwd && s.mr);
        e.drop = 8'(mDrops);

        if (fwd && s.mr) begin
            if (eop[g]) begin
                mLast  = (g == 1);
                mOwner = -1;
            end else begin
                mOwner = g;
            end
        end
        mDrops = (mDrops + orphans > 255) ? 255 : mDrops + orphans;
    endtask

    function automatic stim_t randStim();
        stim_t s;
        s.v0   = ($urandom_range(0, 9) < 7);
        s.sop0 = ($urandom_range(0, 9) < 3);
        s.eop0 = ($urandom_range(0, 9) < 3);
        s.d0   = $urandom;
        s.v1   = ($urandom_range(0, 9) < 7);
        s.sop1 = ($urandom_range(0, 9) < 3);
        s.eop1 = ($urandom_range(0, 9) < 3);
        s.d1   = $urandom;
        s.mr   = ($urandom_range(0, 9) < 8);
        return s;
    endfunction

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        stim_t idle1;
        exp_t  e;
        bit    doRst;
        idle1 = st(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Both ports tie; port 0 packet then port 1 packet back-to-back.
        addVec(st(1, 1, 0, 32'hA000_0000, 1, 1, 0, 32'hB000_0000, 1), ex(1, 32'hA000_0000, 1, 0, 1, 0, 0, 1, 0));
        addVec(st(1, 0, 0, 32'hA000_0001, 1, 1, 0, 32'hB000_0000, 1), ex(1, 32'hA000_0001, 0, 0, 1, 0, 0, 1, 0));
        addVec(st(1, 0, 1, 32'hA000_0002, 1, 1, 0, 32'hB000_0000, 1), ex(1, 32'hA000_0002, 0, 1, 1, 0, 0, 1, 0));
        addVec(st(0, 0, 0, 0, 1, 1, 0, 32'hB000_0000, 1), ex(1, 32'hB000_0000, 1, 0, 0, 1, 1, 1, 0));
        addVec(st(0, 0, 0, 0, 1, 0, 0, 32'hB000_0001, 1), ex(1, 32'hB000_0001, 0, 0, 0, 1, 1, 1, 0));
        addVec(st(0, 0, 0, 0, 1, 0, 1, 32'hB000_0002, 1), ex(1, 32'hB000_0002, 0, 1, 0, 1, 1, 1, 0));
        // Single-word packet on port 1 stays in IDLE with last_served = 1.
        addVec(st(0, 0, 0, 0, 1, 1, 1, 32'hD000_0000, 1), ex(1, 32'hD000_0000, 1, 1, 0, 1, 1, 1, 0));
        addVec(idle1, ex(0, 0, 0, 0, 0, 0, 1, 0, 0));
        // Port 1 orphans while port 0 owns the output.
        addVec(st(1, 1, 0, 32'hE000_0000, 1, 0, 0, 32'hF000_0000, 1), ex(1, 32'hE000_0000, 1, 0, 1, 1, 0, 1, 0));
        addVec(st(1, 0, 0, 32'hE000_0001, 1, 0, 0, 32'hF000_0001, 1), ex(1, 32'hE000_0001, 0, 0, 1, 1, 0, 1, 1));
        addVec(st(0, 0, 0, 0, 1, 0, 0, 32'hF000_0002, 1), ex(0, 0, 0, 0, 1, 1, 0, 1, 2));
        addVec(st(1, 0, 1, 32'hE000_0002, 1, 0, 0, 32'hF000_0003, 1), ex(1, 32'hE000_0002, 0, 1, 1, 1, 0, 1, 3));
        addVec(idle1, ex(0, 0, 0, 0, 0, 0, 0, 0, 4));
        // Backpressure 1,0,0,1 during an OWN1 packet.
        addVec(st(0, 0, 0, 0, 1, 1, 0, 32'h6000_0000, 1), ex(1, 32'h6000_0000, 1, 0, 0, 1, 1, 1, 4));
        addVec(st(0, 0, 0, 0, 1, 0, 0, 32'h6000_0001, 0), ex(1, 32'h6000_0001, 0, 0, 0, 0, 1, 1, 4));
        addVec(st(0, 0, 0, 0, 1, 0, 0, 32'h6000_0001, 0), ex(1, 32'h6000_0001, 0, 0, 0, 0, 1, 1, 4));
        addVec(st(0, 0, 0, 0, 1, 0, 0, 32'h6000_0001, 1), ex(1, 32'h6000_0001, 0, 0, 0, 1, 1, 1, 4));
        addVec(st(0, 0, 0, 0, 1, 0, 1, 32'h6000_0002, 1), ex(1, 32'h6000_0002, 0, 1, 0, 1, 1, 1, 4));
        addVec(idle1, ex(0, 0, 0, 0, 0, 0, 1, 0, 4));
        // Orphans on both ports in one cycle count twice.
        addVec(st(1, 0, 0, 32'h7000_0000, 1, 0, 0, 32'h7100_0000, 1), ex(0, 0, 0, 0, 1, 1, 1, 0, 4));
        addVec(idle1, ex(0, 0, 0, 0, 0, 0, 1, 0, 6));
        // Grant without handshake leaves state and last_served alone.
        addVec(st(1, 1, 0, 32'h8000_0000, 0, 0, 0, 0, 0), ex(1, 32'h8000_0000, 1, 0, 0, 0, 0, 0, 6));
        addVec(idle1, ex(0, 0, 0, 0, 0, 0, 1, 0, 6));

        // Outputs are forced quiet while reset is held, even with sop requests present.
        rst = 1'b1;
        applyStimulus(st(1, 1, 0, 32'h1111_1111, 1, 0, 0, 32'h2222_2222, 1));
        @(negedge clk);
        checkOutput("reset", ex(0, 0, 0, 0, 0, 0, 1, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(idle1);

        for (int i = 0; i < tbl.size(); i++)
            cycle($sformatf("vec%0d", i), tbl[i].s, tbl[i].e);

        // Repeated tie: port 1 now wins under round-robin, port 0 under fixed priority.
        cycle("tie_a", st(1, 1, 1, 32'h9000_0000, 1, 1, 1, 32'h9100_0000, 1), ex(1, 32'h9000_0000, 1, 1, 1, 0, 0, 1, 6));
        if (FIXED)
            e = ex(1, 32'h9000_0000, 1, 1, 1, 0, 0, 1, 6);
        else
            e = ex(1, 32'h9100_0000, 1, 1, 0, 1, 1, 1, 6);
        cycle("tie_b", st(1, 1, 1, 32'h9000_0000, 1, 1, 1, 32'h9100_0000, 1), e);
        cycle("tie_c", idle1, ex(0, 0, 0, 0, 0, 0, FIXED ? 1'b0 : 1'b1, 0, 6));

        // Reset pulsed on the second word of a packet abandons it.
        cycle("rstpkt_0", st(1, 1, 0, 32'hC000_0000, 0, 0, 0, 0, 1), ex(1, 32'hC000_0000, 1, 0, 1, 0, 0, 1, 6));
        cycle("rstpkt_1", st(1, 0, 0, 32'hC000_0001, 0, 0, 0, 0, 1), ex(1, 32'hC000_0001, 0, 0, 1, 0, 0, 1, 6));
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rstpkt_rst", ex(0, 0, 0, 0, 0, 0, 1, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(st(1, 0, 0, 32'hC000_0002, 1, 1, 0, 32'hCC00_0000, 1));
        @(negedge clk);
        checkOutput("rstpkt_2", ex(1, 32'hCC00_0000, 1, 0, 1, 1, 1, 1, 0));
        cycle("rstpkt_3", st(0, 0, 0, 0, 1, 0, 1, 32'hCC00_0001, 1), ex(1, 32'hCC00_0001, 0, 1, 0, 1, 1, 1, 1));

        // Randomized traffic with occasional resets early on, then a long run that saturates drop_cnt.
        doReset();
        mOwner = -1;
        mLast  = 1'b1;
        mDrops = 0;
        for (int c = 0; c < 3000; c++) begin
            stim_t s;
            @(posedge clk);
            #1;
            s = randStim();
            doRst = (c < 1500) && ($urandom_range(0, 149) == 0);
            rst = doRst;
            applyStimulus(s);
            @(negedge clk);
            if (doRst) begin
                mOwner = -1;
                mLast  = 1'b1;
                mDrops = 0;
                checkOutput($sformatf("rand_rst%0d", c), ex(0, 0, 0, 0, 0, 0, 1, 0, 0));
            end else begin
                modelStep(s, e);
                checkOutput($sformatf("rand%0d", c), e);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/unpack_arb.md
UNPACK_ARB -- requirements
Module: unpack_arb

Interface
REQ-001 The block SHALL have these ports: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 The block SHALL have these ports: rst  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL have these ports, for n = 0, 1: sn_valid  input  1  requester n word valid.
REQ-004 The block SHALL have these ports, for n = 0, 1: sn_ready  output  1  requester n word accepted when high with sn_valid.
REQ-005 The block SHALL have these ports, for n = 0, 1: sn_data  input  32  LSB-aligned packed word.
REQ-006 The block SHALL have these ports, for n = 0, 1: sn_sop  input  1  first word of a packet.
REQ-007 The block SHALL have these ports, for n = 0, 1: sn_eop  input  1  last word of a packet.
REQ-008 The block SHALL have these ports: m_valid  output  1  word to the unpacker.
REQ-009 The block SHALL have these ports: m_ready  input  1  unpacker ready_out.
REQ-010 The block SHALL have these ports: m_data  output  32  forwarded word.
REQ-011 The block SHALL have these ports: m_sop and m_eop  output  1 each  forwarded flags.
REQ-012 The block SHALL have these ports: grant_id  output  1  requester currently owning the output.
REQ-013 The block SHALL have these ports: busy  output  1  a packet is in flight.
REQ-014 The block SHALL have these ports: drop_cnt  output  8  saturating count of discarded orphan words.

Function
REQ-015 The block SHALL share one unpacker between two packet sources, with packet-atomic arbitration (no interleaving inside a packet).
REQ-016 The block SHALL implement states IDLE, OWN0 and OWN1.
REQ-017 In IDLE, a requester SHALL be eligible when sn_valid=1 and sn_sop=1.
REQ-018 In IDLE with one eligible requester, that requester SHALL be granted combinationally in the same cycle (0-cycle forward latency).
REQ-019 In IDLE with both requesters eligible, the requester other than last_served SHALL win (round-robin).
REQ-020 The granted word SHALL be forwarded to m_* in the cycle it is granted.
REQ-021 On a granted sop handshake without eop, the state SHALL move to OWNn.
REQ-022 On a granted sop handshake with eop (single-word packet), the state SHALL remain IDLE and last_served SHALL update.
REQ-023 In OWNn, m_valid/m_data/m_sop/m_eop SHALL equal the sn_* inputs, sn_ready SHALL equal m_ready, and the other requester's ready SHALL be 0 unless REQ-027 applies.
REQ-024 In OWNn, a handshake with sn_eop=1 SHALL set last_served=n and return to IDLE on the next edge, with no dead cycle: IDLE arbitrates and forwards in that same next cycle.
REQ-025 In OWNn, a word with sn_sop=1 SHALL be forwarded unchanged (the unpacker restarts) and the state SHALL NOT change.
REQ-026 With m_ready=0, no handshake SHALL occur and state, grant and last_served SHALL hold.
REQ-027 A valid word from a non-owning requester with sn_sop=0 SHALL be an orphan: its sn_ready SHALL be 1, the word SHALL be discarded, and drop_cnt SHALL increment, saturating at 255.
REQ-028 Orphans on both ports in the same cycle SHALL increment drop_cnt by 2, still saturating at 255.
REQ-029 A non-owning requester presenting sop SHALL see sn_ready=0 until it is granted.
REQ-030 busy SHALL be 1 in OWN0/OWN1 and also in IDLE during a granted handshake; grant_id SHALL be the current or same-cycle granted port, else last_served.
REQ-031 When m_valid=0, m_data, m_sop and m_eop SHALL be 0.

Reset
REQ-032 Asserting rst SHALL asynchronously force state=IDLE, last_served=1 (so port 0 wins the first tie) and drop_cnt=0.
REQ-033 While rst is asserted, m_valid, s0_ready, s1_ready and busy SHALL be 0 and grant_id SHALL be 1.
REQ-034 Reset asserted mid-packet SHALL abandon the packet; the next sop after release SHALL be arbitrated normally.

Configuration
REQ-035 With UNPACK_ARB_FIXED_PRIO_EN defined, ties in IDLE SHALL always grant port 0 and last_served SHALL be ignored.
REQ-036 Without UNPACK_ARB_FIXED_PRIO_EN defined, arbitration SHALL be round-robin per REQ-019.

Verification
REQ-037 After reset, both ports present sop with a 3-word packet, m_ready=1 -> port 0 words on cycles 0-2 and port 1 words on cycles 3-5, with no gap.
REQ-038 Repeat REQ-037 immediately -> port 0 is served after port 1 (alternation), while UNPACK_ARB_FIXED_PRIO_EN gives port 0 first every time.
REQ-039 Port 0 mid-packet while port 1 sends 4 words without sop -> s1_ready=1 on each, drop_cnt=4 and m_* carries only port 0 data.
REQ-040 m_ready toggled 1,0,0,1 during an OWN1 packet -> no word lost or duplicated and grant_id=1 throughout.
REQ-041 Single-word packet (sop=eop=1) on port 1 with port 0 idle -> forwarded the same cycle, state stays IDLE and last_served=1.
REQ-042 rst pulsed during the second word of a 5-word packet -> m_valid=0 immediately and a new sop on port 1 after release is granted at once.
